// File: rtl/mi_nios_key_pio.sv
// Avalon-MM pushbutton PIO with input sync, falling-edge capture and a masked level interrupt.
// Optional MI_NIOS_KEY_BITCLR_EN: EDGECAP writes clear per bit instead of clearing all bits.
module mi_nios_key_pio #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] AddrData    = 2'd0;
   localparam logic [1:0] AddrMask    = 2'd2;
   localparam logic [1:0] AddrEdgecap = 2'd3;

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;

   logic             wr_en;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] clr_mask;
   logic [31:0]      data_ext;
   logic [31:0]      mask_ext;
   logic [31:0]      edgecap_ext;
   logic             unused_wdata;

   // Upper writedata bits only matter for wider instances.
   assign unused_wdata = ^writedata;

   assign wr_en = chipselect & ~write_n;
   assign fall  = prev_q & ~sync2_q;

   always_comb begin
      sync1_d   = in_port;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      irqmask_d = irqmask_q;
      clr_mask  = '0;
      if (wr_en && (address == AddrMask)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == AddrEdgecap)) begin
`ifdef MI_NIOS_KEY_BITCLR_EN
         clr_mask = writedata[WIDTH-1:0];
`else
         clr_mask = '1;
`endif
      end
      // A new falling edge in the clearing cycle must not be lost.
      edgecap_d = (edgecap_q & ~clr_mask) | fall;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         irqmask_q <= '0;
         edgecap_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
      end
   end

   always_comb begin
      data_ext                 = '0;
      mask_ext                 = '0;
      edgecap_ext              = '0;
      data_ext[WIDTH-1:0]      = sync2_q;
      mask_ext[WIDTH-1:0]      = irqmask_q;
      edgecap_ext[WIDTH-1:0]   = edgecap_q;
      readdata                 = '0;
      case (address)
         AddrData:    readdata = data_ext;
         AddrMask:    readdata = mask_ext;
         AddrEdgecap: readdata = edgecap_ext;
         default:     readdata = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_mi_nios_key_pio.sv
// Directed table-driven bench for mi_nios_key_pio (WIDTH = 4), plus hand sequences for
// set/clear collision and asynchronous reset.
`timescale 1ns/1ps
module tb_mi_nios_key_pio;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic        cs;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  inp;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[$];

`ifdef MI_NIOS_KEY_BITCLR_EN
   localparam logic [31:0] ExpAfterBitClr = 32'h4;
`else
   localparam logic [31:0] ExpAfterBitClr = 32'h0;
`endif

   mi_nios_key_pio #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic void add(input logic cs, input logic wr, input logic [1:0] a,
                               input logic [31:0] wd, input logic [3:0] ip,
                               input logic [31:0] erd, input logic eirq);
      vec_t v;
      v.cs = cs; v.wr = wr; v.addr = a; v.wdata = wd; v.inp = ip;
      v.exp_rd = erd; v.exp_irq = eirq;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Drive one bus cycle at the falling edge; leave address selected for a read afterwards.
   task automatic step(input logic cs, input logic wr, input logic [1:0] a,
                       input logic [31:0] wd, input logic [3:0] ip);
      @(negedge clk);
      chipselect = cs;
      write_n    = ~wr;
      address    = a;
      writedata  = wd;
      in_port    = ip;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic step_chk(input string name, input logic cs, input logic wr,
                           input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ip,
                           input logic [31:0] erd, input logic eirq);
      step(cs, wr, a, wd, ip);
      check({name, "_rd"}, readdata, erd);
      check({name, "_irq"}, {31'b0, irq}, {31'b0, eirq});
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;

      //   cs    wr    addr  wdata          in    exp_rd         irq
      add(1'b0, 1'b0, 2'd0, 32'h0,         4'hF, 32'h0,         1'b0); // 0 sync1 only
      add(1'b0, 1'b0, 2'd0, 32'h0,         4'hF, 32'hF,         1'b0); // 1 data visible
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hF, 32'h0,         1'b0); // 2 no capture on rise
      add(1'b0, 1'b0, 2'd1, 32'h0,         4'hF, 32'h0,         1'b0); // 3 reserved
      add(1'b1, 1'b1, 2'd2, 32'hFFFF_FFF1, 4'hF, 32'h1,         1'b0); // 4 mask = 1
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hE, 32'h0,         1'b0); // 5 edge 1
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hE, 32'h0,         1'b0); // 6 edge 2
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hE, 32'h1,         1'b1); // 7 edge 3 capture
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hF, 32'h1,         1'b1); // 8 rise keeps
      add(1'b0, 1'b0, 2'd0, 32'h0,         4'hF, 32'hF,         1'b1); // 9
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hF, 32'h1,         1'b1); // 10 read no clear
      add(1'b1, 1'b1, 2'd3, 32'h1,         4'hF, 32'h0,         1'b0); // 11 clear
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hC, 32'h0,         1'b0); // 12
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hC, 32'h0,         1'b0); // 13
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hC, 32'h3,         1'b1); // 14 two bits
      add(1'b1, 1'b1, 2'd2, 32'h2,         4'hC, 32'h2,         1'b1); // 15 mask 2
      add(1'b1, 1'b1, 2'd2, 32'h0,         4'hC, 32'h0,         1'b0); // 16 mask 0
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hC, 32'h3,         1'b0); // 17 still 3
      add(1'b1, 1'b1, 2'd3, 32'hF,         4'hC, 32'h0,         1'b0); // 18 clear all
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hF, 32'h0,         1'b0); // 19
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hF, 32'h0,         1'b0); // 20
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hA, 32'h0,         1'b0); // 21
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hA, 32'h0,         1'b0); // 22
      add(1'b0, 1'b0, 2'd3, 32'h0,         4'hA, 32'h5,         1'b0); // 23 bits 0,2
      add(1'b1, 1'b1, 2'd3, 32'h1,         4'hA, ExpAfterBitClr, 1'b0); // 24
      add(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 4'hA, 32'hA,         1'b0); // 25 DATA RO
      add(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hA, 32'h0,         1'b0); // 26 reserved RO
      add(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 4'hA, 32'h0,         1'b0); // 27 no cs

      // Outputs during reset, combinational from cleared state.
      repeat (2) @(posedge clk);
      for (int a = 0; a < 4; a++) begin
         address = a[1:0];
         #1;
         check($sformatf("in_reset_a%0d", a), readdata, 32'h0);
      end
      check("in_reset_irq", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step_chk($sformatf("vec%0d", i), tbl[i].cs, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                  tbl[i].inp, tbl[i].exp_rd, tbl[i].exp_irq);
      end

      // Clear write in the cycle fall[2] is true: set wins.
      step_chk("pre_clr", 1'b1, 1'b1, 2'd3, 32'hF, 4'hA, 32'h0, 1'b0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'hF);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'hF);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'hB);
      step_chk("fall2_pending", 1'b0, 1'b0, 2'd3, 32'h0, 4'hB, 32'h0, 1'b0);
      step_chk("set_wins", 1'b1, 1'b1, 2'd3, 32'hF, 4'hB, 32'h4, 1'b0);
      step_chk("set_holds", 1'b0, 1'b0, 2'd3, 32'h0, 4'hB, 32'h4, 1'b0);

      // Fill EDGECAP and mask, then reset mid-cycle.
      step(1'b1, 1'b1, 2'd3, 32'hF, 4'hB);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'hF);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'hF);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step_chk("all_cap", 1'b0, 1'b0, 2'd3, 32'h0, 4'h0, 32'hF, 1'b0);
      step_chk("mask_all", 1'b1, 1'b1, 2'd2, 32'hF, 4'h0, 32'hF, 1'b1);
      #1;
      reset_n = 1'b0;
      address = 2'd3;
      #1;
      check("async_rst_a3", readdata, 32'h0);
      check("async_rst_irq", {31'b0, irq}, 32'h0);
      address = 2'd2;
      #1;
      check("async_rst_a2", readdata, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Low input across release: no capture, mask cleared.
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step_chk("post_rst_nocap", 1'b0, 1'b0, 2'd3, 32'h0, 4'h0, 32'h0, 1'b0);
      step_chk("post_rst_mask", 1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h9);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h9);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step(1'b0, 1'b0, 2'd3, 32'h0, 4'h0);
      step_chk("post_rst_newcap", 1'b0, 1'b0, 2'd3, 32'h0, 4'h0, 32'h9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
